// File: rtl/tt_um_array_div_joe_leighthardt_if.sv
// Tiny Tapeout tile pin bundle for the array divider.
//   ena     : tile enable (ignored by the divider)
//   ui_in   : dividend N[7:0]
//   uio_in  : [3:0] divisor D, [4] start, [5] sel, [7:6] unused
//   uo_out  : quotient, or {4'b0, remainder} when sel=1
//   uio_out : [6] busy, [7] done, [5:0] zero
//   uio_oe  : constant 8'hC0
// The master drives the inputs (harness / testbench); the slave is the tile.
interface tt_um_array_div_joe_leighthardt_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_array_div_joe_leighthardt.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor ->
// 8-bit quotient + 4-bit remainder, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tile pins (see tt_um_array_div_joe_leighthardt_if)
// A rising edge on start launches an operation from IDLE or DONE. Divide
// by zero finishes immediately with Q=8'hFF, R=4'hF. Results are held until
// the next operation completes.
module tt_um_array_div_joe_leighthardt (
    input  logic clk,
    input  logic rst_n,
    tt_um_array_div_joe_leighthardt_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     r_state, w_state_nx;
    logic       r_start_q;
    logic [7:0] r_a;      // dividend shifting out, quotient shifting in
    logic [3:0] r_b;      // latched divisor
    logic [4:0] r_p;      // partial remainder
    logic [2:0] r_cnt;
    logic [7:0] r_q;
    logic [3:0] r_r;

    logic [3:0] w_d;
    logic       w_start, w_sel, w_go, w_ge, w_last;
    logic [4:0] w_t, w_p_nx;
    logic [7:0] w_a_nx;
    logic [2:0] w_unused;

    assign w_d      = bus.uio_in[3:0];
    assign w_start  = bus.uio_in[4];
    assign w_sel    = bus.uio_in[5];
    assign w_unused = {bus.ena, bus.uio_in[7:6]};
    assign w_go     = w_start & ~r_start_q;
    assign w_last   = (r_cnt == 3'd7);

    // One restoring step: bring the next dividend bit into the remainder and
    // subtract the divisor if it fits. P < B always holds, so t fits 5 bits.
    assign w_t    = {r_p[3:0], r_a[7]};
    assign w_ge   = (w_t >= {1'b0, r_b});
    assign w_p_nx = w_ge ? (w_t - {1'b0, r_b}) : w_t;
    assign w_a_nx = {r_a[6:0], w_ge};

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_go) w_state_nx = (w_d == 4'd0) ? S_DONE : S_RUN;
            S_RUN:          if (w_last) w_state_nx = S_DONE;
            default:        w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_start_q <= w_start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go) begin
                        r_a   <= bus.ui_in;
                        r_b   <= w_d;
                        r_p   <= '0;
                        r_cnt <= '0;
                        if (w_d == 4'd0) begin
                            r_q <= 8'hFF;
                            r_r <= 4'hF;
                        end
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_nx;
                    r_p   <= w_p_nx;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_q <= w_a_nx;
                        r_r <= w_p_nx[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.uo_out  = w_sel ? {4'b0000, r_r} : r_q;
    assign bus.uio_out = {r_state == S_DONE, r_state == S_RUN, 6'b000000};
    assign bus.uio_oe  = 8'hC0;
endmodule

// File: tb/tb_tt_um_array_div_joe_leighthardt.sv
module tb_tt_um_array_div_joe_leighthardt;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] tb_n = 8'd0;
    logic [3:0] tb_d = 4'd0;
    logic tb_start = 1'b0;
    logic tb_sel = 1'b0;
    int checks = 0;
    int errors = 0;

    tt_um_array_div_joe_leighthardt_if bus ();
    assign bus.ena    = 1'b1;
    assign bus.ui_in  = tb_n;
    assign bus.uio_in = {2'b00, tb_sel, tb_start, tb_d};

    tt_um_array_div_joe_leighthardt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_res(output logic [7:0] q, output logic [7:0] r);
        tb_sel = 1'b0; #1; q = bus.uo_out;
        tb_sel = 1'b1; #1; r = bus.uo_out;
        tb_sel = 1'b0; #1;
    endtask

    // Pulse start for one edge, then count busy samples until done.
    task automatic run_op(input logic [7:0] n, input logic [3:0] d,
                          output logic [7:0] q, output logic [7:0] r,
                          output int busy_cnt, output bit seen);
        @(negedge clk);
        tb_n = n; tb_d = d; tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        busy_cnt = 0; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.uio_out[7]) begin seen = 1'b1; break; end
            if (bus.uio_out[6]) busy_cnt++;
            @(negedge clk);
        end
        read_res(q, r);
    endtask

    initial begin
        logic [7:0] q, r, prev_q;
        int bc, gos;
        bit seen, prev_busy;

        // Reset state
        #1;
        chk("rst_uo_q", bus.uo_out, 8'h00);
        tb_sel = 1'b1; #1;
        chk("rst_uo_r", bus.uo_out, 8'h00);
        tb_sel = 1'b0;
        chk("rst_uio_out", bus.uio_out, 8'h00);
        chk("rst_oe", bus.uio_oe, 8'hC0);
        @(negedge clk); rst_n = 1'b1;

        // 200 / 7
        run_op(8'd200, 4'd7, q, r, bc, seen);
        chk("200_7_done", seen, 1'b1);
        chk("200_7_q", q, 8'h1C);
        chk("200_7_r", r, 8'h04);
        chk("200_7_busy8", bc, 8);
        chk("200_7_oe", bus.uio_oe, 8'hC0);
        chk("200_7_uio_lo", bus.uio_out[5:0], 6'd0);
        chk("200_7_flags", bus.uio_out, 8'h80);

        // Boundary vectors
        run_op(8'd255, 4'd1, q, r, bc, seen);
        chk("255_1_q", q, 8'hFF); chk("255_1_r", r, 8'h00);
        run_op(8'd5, 4'd9, q, r, bc, seen);
        chk("5_9_q", q, 8'h00); chk("5_9_r", r, 8'h05);
        run_op(8'd0, 4'd15, q, r, bc, seen);
        chk("0_15_q", q, 8'h00); chk("0_15_r", r, 8'h00);
        run_op(8'd255, 4'd15, q, r, bc, seen);
        chk("255_15_q", q, 8'h11); chk("255_15_r", r, 8'h00);

        // Divide by zero: done after the go edge, busy never seen
        run_op(8'd42, 4'd0, q, r, bc, seen);
        chk("div0_done", seen, 1'b1);
        chk("div0_busy", bc, 0);
        chk("div0_q", q, 8'hFF); chk("div0_r", r, 8'h0F);

        // Start held high 30 cycles: one operation, old result held during RUN
        @(negedge clk);
        tb_n = 8'd50; tb_d = 4'd5; tb_start = 1'b1;
        gos = 0; prev_busy = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.uio_out[6] && !prev_busy) gos++;
            prev_busy = bus.uio_out[6];
            if (k == 2) chk("hold_prev_q", bus.uo_out, 8'hFF);
        end
        tb_start = 1'b0;
        chk("held_one_op", gos, 1);
        chk("held_done", bus.uio_out, 8'h80);
        read_res(q, r);
        chk("held_q", q, 8'd10); chk("held_r", r, 8'd0);

        // Second start pulse during RUN is ignored
        @(negedge clk);
        tb_n = 8'd77; tb_d = 4'd4; tb_start = 1'b1;
        @(negedge clk); tb_start = 1'b0;
        @(negedge clk); @(negedge clk);
        tb_n = 8'd9; tb_d = 4'd2; tb_start = 1'b1;
        @(negedge clk); tb_start = 1'b0;
        for (int k = 0; k < 20 && !bus.uio_out[7]; k++) @(negedge clk);
        chk("ign_done", bus.uio_out, 8'h80);
        read_res(q, r);
        chk("ign_q", q, 8'd19); chk("ign_r", r, 8'd1);
        @(negedge clk);
        chk("ign_no_rerun", bus.uio_out, 8'h80);

        // Async reset at RUN cycle 4
        @(negedge clk);
        tb_n = 8'd200; tb_d = 4'd7; tb_start = 1'b1;
        @(negedge clk); tb_start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("mid_busy", bus.uio_out, 8'h40);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_uio_out", bus.uio_out, 8'h00);
        chk("arst_uo_q", bus.uo_out, 8'h00);
        tb_sel = 1'b1; #1;
        chk("arst_uo_r", bus.uo_out, 8'h00);
        tb_sel = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_op(8'd100, 4'd3, q, r, bc, seen);
        chk("100_3_q", q, 8'd33); chk("100_3_r", r, 8'd1);

        // Sweep every dividend against every non-zero divisor
        for (int n = 0; n < 256; n++) begin
            for (int d = 1; d < 16; d++) begin
                run_op(n[7:0], d[3:0], q, r, bc, seen);
                if (!seen) chk($sformatf("sw_to_%0d_%0d", n, d), seen, 1'b1);
                chk($sformatf("sw_q_%0d_%0d", n, d), q, n / d);
                chk($sformatf("sw_r_%0d_%0d", n, d), r, n % d);
                chk("sw_pins", {bus.uio_oe, 2'b00, bus.uio_out[5:0]}, 16'hC000);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog observed timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
